// File: rtl/histo_pkg.sv
// Shared defaults and FSM state encoding for the histogram accumulator.
// Optional saturation is selected by HISTO_SATURATE_EN.
package histo_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int CNT_W_DEF = 20;
  localparam int NUM_BINS  = 2 ** PIX_W_DEF;

  typedef logic [0:0] state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t ACCUM = 1'b1;

endpackage

// File: rtl/histo_if.sv
// Pixel-stream and display-read bundle for histogram_accumulator.
// master drives stimulus; slave is the accumulator.
interface histo_if #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 20
);

  logic             iFrameStart;
  logic             iPixelValid;
  logic [PIX_W-1:0] iPixel;
  logic [PIX_W-1:0] iHistoAddr;
  logic [CNT_W-1:0] oHistoValue;
  logic [CNT_W-1:0] oPixelTotal;
  logic             oBusy;
  logic             oDropped;

  modport master (
    output iFrameStart, iPixelValid, iPixel, iHistoAddr,
    input  oHistoValue, oPixelTotal, oBusy, oDropped
  );

  modport slave (
    input  iFrameStart, iPixelValid, iPixel, iHistoAddr,
    output oHistoValue, oPixelTotal, oBusy, oDropped
  );

endinterface

// File: rtl/histo_bank_ram.sv
// One histogram bank: 1 write + 1 registered read port.
// A read colliding with a write returns the old contents.
module histo_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/histogram_accumulator.sv
// Double-buffered 2**PIX_W-bin histogram with RMW forwarding.
// Define HISTO_SATURATE_EN for saturating bins/totals (default: wrap).
module histogram_accumulator
  import histo_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic     iClk,
  input logic     iRst,
  histo_if.slave  bus
);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
`ifdef HISTO_SATURATE_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  state_t           state;
  logic [PIX_W-1:0] ptr;
  logic             wbank;
  logic             clear_both;
  logic             disp_sel;
  logic             a_valid;
  logic [PIX_W-1:0] a_bin;
  logic             b_valid;
  logic [PIX_W-1:0] b_bin;
  logic [CNT_W-1:0] b_new;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] pix_total;
  logic             dropped;

  logic             busy;
  logic             accept;
  logic             fwd;
  logic [CNT_W-1:0] ram_q;
  logic [CNT_W-1:0] nv;
  logic             we0, we1;
  logic [PIX_W-1:0] waddr;
  logic [CNT_W-1:0] wdata;
  logic [PIX_W-1:0] ra0, ra1;
  logic [CNT_W-1:0] rd0, rd1;

  assign busy   = (state == CLEAR);
  assign accept = !busy && bus.iPixelValid && !bus.iFrameStart;
  assign ram_q  = wbank ? rd1 : rd0;
  assign fwd    = a_valid && b_valid && (a_bin == b_bin);
  assign nv     = inc(fwd ? b_new : ram_q);

  // Write bank reads for RMW; the other bank serves the display.
  assign ra0 = wbank ? bus.iHistoAddr : bus.iPixel;
  assign ra1 = wbank ? bus.iPixel : bus.iHistoAddr;

  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    waddr = a_bin;
    wdata = nv;
    if (busy) begin
      waddr = ptr;
      wdata = '0;
      we0   = clear_both || !wbank;
      we1   = clear_both || wbank;
    end else begin
      we0 = a_valid && !wbank;
      we1 = a_valid && wbank;
    end
  end

  histo_bank_ram #(.AW(PIX_W), .DW(CNT_W)) u_bank0 (
    .clk(iClk), .rst(iRst), .we(we0), .waddr(waddr),
    .wdata(wdata), .raddr(ra0), .rdata(rd0)
  );

  histo_bank_ram #(.AW(PIX_W), .DW(CNT_W)) u_bank1 (
    .clk(iClk), .rst(iRst), .we(we1), .waddr(waddr),
    .wdata(wdata), .raddr(ra1), .rdata(rd1)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= CLEAR;
      ptr        <= '0;
      wbank      <= 1'b0;
      clear_both <= 1'b1;
      disp_sel   <= 1'b1;
      a_valid    <= 1'b0;
      a_bin      <= '0;
      b_valid    <= 1'b0;
      b_bin      <= '0;
      b_new      <= '0;
      total      <= '0;
      pix_total  <= '0;
      dropped    <= 1'b0;
    end else begin
      a_valid  <= accept;
      a_bin    <= bus.iPixel;
      b_valid  <= a_valid;
      b_bin    <= a_bin;
      b_new    <= nv;
      disp_sel <= ~wbank;
      if (bus.iPixelValid && !accept) dropped <= 1'b1;
      if (accept) total <= inc(total);
      unique case (state)
        CLEAR: begin
          if (bus.iFrameStart) begin
            ptr <= '0;
          end else begin
            ptr <= ptr + 1'b1;
            if (&ptr) begin
              state      <= ACCUM;
              clear_both <= 1'b0;
            end
          end
        end
        ACCUM: begin
          // The last B write lands in the old bank this cycle.
          if (bus.iFrameStart) begin
            wbank     <= ~wbank;
            pix_total <= total;
            total     <= '0;
            ptr       <= '0;
            state     <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.oHistoValue = disp_sel ? rd1 : rd0;
  assign bus.oPixelTotal = pix_total;
  assign bus.oBusy       = busy;
  assign bus.oDropped    = dropped;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Self-checking bench: wide (20-bit) and narrow (4-bit) counters vs a frame-level model.
// Expectations follow HISTO_SATURATE_EN when defined.
module tb_histogram_accumulator;

`ifdef HISTO_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       fs;
  logic       pv;
  logic [7:0] pix;
  logic [7:0] ha;
  bit         rand_addr;

  int checks;
  int failures;

  histo_if #(.PIX_W(8), .CNT_W(20)) ifa ();
  histo_if #(.PIX_W(8), .CNT_W(4))  ifb ();

  assign ifa.iFrameStart = fs;
  assign ifa.iPixelValid = pv;
  assign ifa.iPixel      = pix;
  assign ifa.iHistoAddr  = ha;
  assign ifb.iFrameStart = fs;
  assign ifb.iPixelValid = pv;
  assign ifb.iPixel      = pix;
  assign ifb.iHistoAddr  = ha;

  histogram_accumulator #(.PIX_W(8), .CNT_W(20)) u_dut (
    .iClk(clk), .iRst(rst), .bus(ifa)
  );

  histogram_accumulator #(.PIX_W(8), .CNT_W(4)) u_nar (
    .iClk(clk), .iRst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: per-bin counts, display copy, clear countdown
  int  m_acc  [2][256];
  int  m_disp [2][256];
  int  m_total[2];
  int  m_ptot [2];
  int  m_max  [2];
  int  hv_exp [2];
  bit  hv_ok;
  bit  m_drop;
  bit  init_done;
  bit  started;
  int  busy_left;

  function automatic int inc_m(input int v, input int mx);
    if (v == mx) return SAT ? mx : 0;
    return v + 1;
  endfunction

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", n, got, exp);
    end
  endtask

  initial begin
    m_max[0] = (1 << 20) - 1;
    m_max[1] = 15;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++)
        hv_exp[k] = rst ? 0 : m_disp[k][ha];
      hv_ok = rst || init_done;
      if (rst) begin
        started   = 1'b1;
        init_done = 1'b0;
        busy_left = 256;
        m_drop    = 1'b0;
        for (int k = 0; k < 2; k++) begin
          m_total[k] = 0;
          m_ptot[k]  = 0;
          for (int b = 0; b < 256; b++) begin
            m_acc[k][b]  = 0;
            m_disp[k][b] = 0;
          end
        end
      end else if (started) begin
        if (pv && (busy_left > 0 || fs)) m_drop = 1'b1;
        if (busy_left > 0) begin
          if (fs) busy_left = 256;
          else begin
            busy_left--;
            if (busy_left == 0) init_done = 1'b1;
          end
        end else if (fs) begin
          for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 256; b++) begin
              m_disp[k][b] = m_acc[k][b];
              m_acc[k][b]  = 0;
            end
            m_ptot[k]  = m_total[k];
            m_total[k] = 0;
          end
          busy_left = 256;
        end else if (pv) begin
          for (int k = 0; k < 2; k++) begin
            m_acc[k][pix] = inc_m(m_acc[k][pix], m_max[k]);
            m_total[k]    = inc_m(m_total[k], m_max[k]);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("busy_a", 32'(ifa.oBusy), 32'(busy_left > 0));
      chk("busy_b", 32'(ifb.oBusy), 32'(busy_left > 0));
      chk("drop_a", 32'(ifa.oDropped), 32'(m_drop));
      chk("drop_b", 32'(ifb.oDropped), 32'(m_drop));
      chk("ptot_a", 32'(ifa.oPixelTotal), m_ptot[0]);
      chk("ptot_b", 32'(ifb.oPixelTotal), m_ptot[1]);
      if (hv_ok) begin
        chk("hv_a", 32'(ifa.oHistoValue), hv_exp[0]);
        chk("hv_b", 32'(ifb.oHistoValue), hv_exp[1]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_addr)
      ha = ($urandom % 2 == 0) ? 8'($urandom_range(0, 7))
                               : 8'($urandom_range(0, 255));
  endtask

  task automatic push(input int p);
    pv  = 1'b1;
    pix = 8'(p);
    step();
  endtask

  task automatic frame_start(input bit with_pix);
    fs = 1'b1;
    pv = with_pix;
    step();
    fs = 1'b0;
    pv = 1'b0;
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    while (ifa.oBusy && n < 600) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input string n);
    int c;
    busy_cycles(c);
    if (ifa.oBusy) begin
      checks++;
      failures++;
      $display("FAIL %s got=busy expected=idle", n);
    end
  endtask

  task automatic read_lit(input string n, input int a,
                          input int e0, input int e1);
    ha = 8'(a);
    step();
    chk({n, "_a"}, 32'(ifa.oHistoValue), e0);
    chk({n, "_b"}, 32'(ifb.oHistoValue), e1);
    chk({n, "_model"}, m_disp[0][a], e0);
  endtask

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    rand_addr = 1'b0;
    rst = 1'b1; fs = 1'b0; pv = 1'b0; pix = '0; ha = '0;

    // Reset and initial clear
    repeat (3) step();
    chk("rst_busy", 32'(ifa.oBusy), 1);
    chk("rst_drop", 32'(ifa.oDropped), 0);
    chk("rst_ptot", 32'(ifa.oPixelTotal), 0);
    chk("rst_hv", 32'(ifa.oHistoValue), 0);
    rst = 1'b0;
    busy_cycles(n);
    chk("init_clear_len", n, 256);
    read_lit("init_bin0", 0, 0, 0);
    read_lit("init_bin255", 255, 0, 0);

    // Back-to-back forwarding
    push(5); push(5); push(5); push(9);
    frame_start(1'b0);
    wait_idle("idle_t2");
    read_lit("t2_bin5", 5, 3, 3);
    read_lit("t2_bin9", 9, 1, 1);
    read_lit("t2_bin6", 6, 0, 0);
    chk("t2_ptot", 32'(ifa.oPixelTotal), 4);

    // Alternating bins, 1000 pixels
    for (int i = 0; i < 1000; i++) push((i % 2 == 0) ? 7 : 8);
    frame_start(1'b0);
    wait_idle("idle_t3");
    read_lit("t3_bin7", 7, 500, SAT ? 15 : 4);
    read_lit("t3_bin8", 8, 500, SAT ? 15 : 4);
    chk("t3_ptot", 32'(ifa.oPixelTotal), 1000);
    for (int i = 0; i < 200; i++) push($urandom_range(0, 15));
    pv = 1'b0;
    read_lit("t3_frozen7", 7, 500, SAT ? 15 : 4);
    chk("t3_nodrop", 32'(ifa.oDropped), 0);

    // Drops on the swap cycle and during clear
    frame_start(1'b1);
    chk("t4_drop_fs", 32'(ifa.oDropped), 1);
    push(3);
    pv = 1'b0;
    wait_idle("idle_t4");
    chk("t4_drop_sticky", 32'(ifb.oDropped), 1);

    // Frame start mid-clear restarts the pointer
    push(42); push(42); push(42);
    frame_start(1'b0);
    repeat (100) step();
    frame_start(1'b0);
    busy_cycles(n);
    chk("t5_restart_len", n, 256);
    read_lit("t5_bin42", 42, 3, 3);
    chk("t5_ptot", 32'(ifa.oPixelTotal), 3);

    // Counter limit on the narrow instance
    for (int i = 0; i < 17; i++) push(200);
    frame_start(1'b0);
    wait_idle("idle_t6");
    read_lit("t6_bin200", 200, 17, SAT ? 15 : 1);
    chk("t6_ptot_a", 32'(ifa.oPixelTotal), 17);
    chk("t6_ptot_b", 32'(ifb.oPixelTotal), SAT ? 15 : 1);

    // Random frames with random display reads
    rand_addr = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 300; i++) begin
        pv  = ($urandom % 4) != 0;
        pix = 8'($urandom_range(0, 7));
        step();
      end
      frame_start(1'b0);
      for (int i = 0; i < 40; i++) begin
        pv  = ($urandom % 8) == 0;
        pix = 8'($urandom_range(0, 7));
        step();
      end
      pv = 1'b0;
      wait_idle("idle_rand");
      repeat (300) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
